fifo_stream_adapter: RTL and testbench
======================================

FIFO_STREAM_ADAPTER -- requirements
Module: fifo_stream_adapter

Interface
REQ-001 The module SHALL have parameter DWIDTH, default 64, meaning the data word width in bits.
REQ-002 The module SHALL have parameter RD_LATENCY, default 1, legal values 1 and 2, meaning the cycles from upstream FIFO rdreq to valid q.
REQ-003 The module SHALL derive the local constant DEPTH = RD_LATENCY + 2, the number of skid buffer entries.
REQ-004 clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 srst_ni  input  1  reset, synchronous and active-low.
REQ-006 fifo_q_i  input  DWIDTH  upstream FIFO read data (non-showahead).
REQ-007 fifo_empty_i  input  1  upstream FIFO empty flag.
REQ-008 fifo_rdreq_o  output  1  read request to upstream FIFO.
REQ-009 data_o  output  DWIDTH  stream data.
REQ-010 valid_o  output  1  stream data valid.
REQ-011 ready_i  input  1  downstream ready.
REQ-012 beats_o  output  32  count of completed stream handshakes.

Function
REQ-013 The module SHALL assert fifo_rdreq_o iff srst_ni=1, fifo_empty_i=0 and (occ + infl) < DEPTH, using registered occ (buffered words) and infl (issued, not yet returned reads).
REQ-014 fifo_rdreq_o SHALL NOT depend combinationally on ready_i.
REQ-015 A read issued in cycle c SHALL be captured from fifo_q_i at the end of cycle c+RD_LATENCY, via a RD_LATENCY-deep valid-bit shift register.
REQ-016 Captured words SHALL go into a DEPTH-entry circular buffer with registered write and read pointers of width clog2(DEPTH); pointers wrap from DEPTH-1 to 0.
REQ-017 valid_o SHALL equal (occ != 0); data_o SHALL be the entry at the read pointer and SHALL be held stable while valid_o=1 and ready_i=0.
REQ-018 A handshake occurs when valid_o=1 and ready_i=1; it SHALL advance the read pointer, decrement occ, and increment beats_o by 1, all in the next cycle.
REQ-019 beats_o SHALL wrap from 2^32-1 to 0.
REQ-020 A simultaneous capture and handshake SHALL leave occ unchanged and advance both pointers.
REQ-021 The first-word latency SHALL be RD_LATENCY+1 cycles: rdreq in cycle c gives valid_o=1 in cycle c+RD_LATENCY+1.
REQ-022 With ready_i held 1 and the upstream FIFO never empty, the module SHALL sustain one handshake per cycle after the first-word latency.
REQ-023 Word order on data_o SHALL equal upstream read order, with no loss or duplication.
REQ-024 occ + infl SHALL never exceed DEPTH, and the buffer SHALL never be overwritten.
REQ-025 Any change on fifo_q_i in a cycle with no expected capture SHALL be ignored.

Reset
REQ-026 While srst_ni=0 at a clock edge, the module SHALL clear occ, infl, the valid-bit shift register, both pointers and beats_o to 0.
REQ-027 During and after reset, valid_o SHALL read 0 and fifo_rdreq_o SHALL read 0 while srst_ni=0.
REQ-028 Reads in flight when reset asserts SHALL be discarded; their data arriving after reset release SHALL NOT be captured.
REQ-029 Buffer RAM contents SHALL need no reset.

Verification
REQ-030 Latency: RD_LATENCY=1, upstream holds 0xA1 then 0xA2, ready_i=1 -> rdreq_o high in cycles 0 and 1, data_o=0xA1 with valid_o in cycle 2, 0xA2 in cycle 3, beats_o=2 in cycle 4.
REQ-031 Throughput: RD_LATENCY=2, 100 words 0..99, ready_i=1 -> 100 consecutive valid cycles starting at cycle 3, in order, beats_o=100.
REQ-032 Backpressure: ready_i=0 with upstream non-empty -> exactly DEPTH reads issued, data_o stable at the first word; ready_i=1 afterwards -> all words delivered in order, none lost.
REQ-033 Random: random fifo_empty_i and ready_i over 10k cycles, both latencies -> scoreboard matches, occ+infl<=DEPTH every cycle.
REQ-034 Reset mid-flight: srst_ni=0 one cycle after a read, with a stale word on fifo_q_i afterwards -> valid_o=0, beats_o=0, stale word never emitted.
REQ-035 Wrap: preload beats_o near 2^32-1 via 3 handshakes from forced 0xFFFFFFFE -> beats_o reads 0xFFFFFFFF, 0x00000000, 0x00000001.

Source files
------------

// File: rtl/fifo_stream_adapter.sv
// fifo_stream_adapter: non-showahead FIFO to valid/ready stream bridge with credit-based skid buffer
module fifo_stream_adapter #(
   parameter int DWIDTH     = 64,
   parameter int RD_LATENCY = 1
) (
   input  logic              clk_i,
   input  logic              srst_ni,
   input  logic [DWIDTH-1:0] fifo_q_i,
   input  logic              fifo_empty_i,
   output logic              fifo_rdreq_o,
   output logic [DWIDTH-1:0] data_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [31:0]       beats_o
);
   localparam int DEPTH = RD_LATENCY + 2;
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = $clog2(DEPTH + 1);

   logic [DWIDTH-1:0]     mem [DEPTH];
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [CW-1:0]         occ;
   logic [CW-1:0]         infl;
   logic [RD_LATENCY-1:0] vld_sr;
   logic [31:0]           beats_q;
   logic                  cap;
   logic                  hs;

   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // read credit counts buffered plus in-flight words so a request is only made when a slot is guaranteed
   always_comb begin
      valid_o      = occ != '0;
      data_o       = mem[rd_ptr];
      beats_o      = beats_q;
      cap          = vld_sr[RD_LATENCY-1];
      hs           = valid_o & ready_i;
      fifo_rdreq_o = srst_ni & ~fifo_empty_i & ((occ + infl) < CW'(DEPTH));
   end

   // control state: capture pipe, pointers, occupancy, in-flight count and beat counter
   always_ff @(posedge clk_i) begin
      if (!srst_ni) begin
         vld_sr  <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         occ     <= '0;
         infl    <= '0;
         beats_q <= '0;
      end else begin
         vld_sr  <= RD_LATENCY'({vld_sr, fifo_rdreq_o});
         infl    <= infl + CW'(fifo_rdreq_o) - CW'(cap);
         occ     <= occ + CW'(cap) - CW'(hs);
         wr_ptr  <= cap ? inc(wr_ptr) : wr_ptr;
         rd_ptr  <= hs ? inc(rd_ptr) : rd_ptr;
         beats_q <= beats_q + 32'(hs);
      end
   end

   // buffer storage, written only when an expected read returns; contents need no reset
   always_ff @(posedge clk_i) begin
      if (srst_ni && cap)
         mem[wr_ptr] <= fifo_q_i;
   end
endmodule

// File: tb/tb_fifo_stream_adapter.sv
// tb_fifo_stream_adapter: scoreboard bench running both read latencies side by side
module tb_fifo_stream_adapter;
   typedef struct {
      logic [31:0] d;
      int          c;
   } ent_t;

   logic        clk_i = 1'b0;
   logic        rst_n = 1'b0;
   logic        empty = 1'b1;
   logic        ready = 1'b0;
   logic [31:0] base  = '0;
   logic [31:0] q     [2];
   logic [31:0] data  [2];
   logic [31:0] beats [2];
   logic        rdreq [2];
   logic        valid [2];
   bit   [31:0] hold_d [2];
   bit   [31:0] w_s    [2];
   bit   [31:0] pw     [2][2];
   bit   [31:0] nb     [2];
   bit          rd_s   [2];
   bit          pv     [2][2];
   bit          hold_p [2];
   ent_t        exp_q  [2][$];
   int          due_q  [2][$];
   int          issued [2];
   int          checks = 0;
   int          errors = 0;
   int          cyc    = 0;
   int          ws     = 0;
   bit          chk_drain = 0;
   bit          wrap_go   = 0;
   bit          done      = 0;
   bit          rst_prev  = 1;

   fifo_stream_adapter #(.DWIDTH(32), .RD_LATENCY(1)) d1 (
      .clk_i(clk_i), .srst_ni(rst_n), .fifo_q_i(q[0]), .fifo_empty_i(empty),
      .fifo_rdreq_o(rdreq[0]), .data_o(data[0]), .valid_o(valid[0]), .ready_i(ready), .beats_o(beats[0]));

   fifo_stream_adapter #(.DWIDTH(32), .RD_LATENCY(2)) d2 (
      .clk_i(clk_i), .srst_ni(rst_n), .fifo_q_i(q[1]), .fifo_empty_i(empty),
      .fifo_rdreq_o(rdreq[1]), .data_o(data[1]), .valid_o(valid[1]), .ready_i(ready), .beats_o(beats[1]));

   always #5 clk_i = ~clk_i;

   task automatic chk(input bit ok, input string nm, input int i, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s L=%0d cycle %0d: got %h expected %h", nm, i + 1, cyc, act, req);
      end
   endtask

   // upstream FIFO model: a read returns its word L cycles later, otherwise q carries junk
   always @(posedge clk_i) begin
      #1;
      for (int i = 0; i < 2; i++) begin
         pv[i][1] = pv[i][0];
         pw[i][1] = pw[i][0];
         pv[i][0] = rd_s[i];
         pw[i][0] = w_s[i];
         q[i] = pv[i][i] ? pw[i][i] : (32'hBAD0_0000 | 32'(cyc));
      end
   end

   // monitor and scoreboard
   always @(negedge clk_i) begin
      ent_t e;
      if (done) begin
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end
      cyc++;
      for (int i = 0; i < 2; i++) begin
         chk(rdreq[i] == (rst_n && !empty && exp_q[i].size() < i + 3), "rdreq", i,
             32'(rdreq[i]), 32'(rst_n && !empty && exp_q[i].size() < i + 3));
         rd_s[i] = rdreq[i];
         w_s[i] = base + 32'(issued[i]);
         if (!rst_n) begin
            if (chk_drain && rst_prev)
               chk(exp_q[i].size() == 0, "undelivered", i, 32'(exp_q[i].size()), 0);
            exp_q[i].delete();
            due_q[i].delete();
            issued[i] = 0;
            hold_p[i] = 0;
         end else begin
            if (!rst_prev) begin
               chk(!valid[i], "valid_after_reset", i, 32'(valid[i]), 0);
               nb[i] = 0;
            end
            chk(beats[i] == nb[i], "beats", i, beats[i], nb[i]);
            while (due_q[i].size() != 0 && due_q[i][0] == cyc) begin
               chk(valid[i], "first_word_latency", i, 32'(valid[i]), 1);
               void'(due_q[i].pop_front());
            end
            if (hold_p[i])
               chk(valid[i] && data[i] == hold_d[i], "hold_stable", i, data[i], hold_d[i]);
            if (valid[i] && ready) begin
               chk(exp_q[i].size() != 0, "extra_word", i, data[i], 0);
               if (exp_q[i].size() != 0) begin
                  e = exp_q[i].pop_front();
                  chk(data[i] == e.d, "data", i, data[i], e.d);
                  chk(cyc >= e.c + i + 2, "too_early", i, 32'(cyc), 32'(e.c + i + 2));
               end
               nb[i]++;
            end
            hold_p[i] = valid[i] && !ready;
            hold_d[i] = data[i];
            if (rdreq[i]) begin
               exp_q[i].push_back('{base + 32'(issued[i]), cyc});
               due_q[i].push_back(cyc + i + 2);
               issued[i]++;
            end
         end
      end
      if (wrap_go && ws == 0) begin
         force d1.beats_q = 32'hFFFF_FFFE;
         force d2.beats_q = 32'hFFFF_FFFE;
         nb[0] = 32'hFFFF_FFFE;
         nb[1] = 32'hFFFF_FFFE;
         ws = 1;
      end else if (ws == 1) begin
         release d1.beats_q;
         release d2.beats_q;
         ws = 2;
      end
      rst_prev = rst_n;
   end

   task automatic drv(input int n, input bit r, input bit e, input bit rd);
      rst_n = r;
      empty = e;
      ready = rd;
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   task automatic rnd(input int n);
      repeat (n) begin
         empty = ($urandom_range(99) < 30);
         ready = ($urandom_range(99) < 60);
         @(posedge clk_i);
         #1;
      end
   endtask

   initial begin
      drv(3, 0, 1, 0);
      chk_drain = 1;
      // two words 0xA1, 0xA2 with ready held high
      base = 32'hA1;
      drv(2, 1, 0, 1);
      drv(8, 1, 1, 1);
      // 100-word streaming run
      base = 32'h0;
      drv(2, 0, 1, 0);
      drv(100, 1, 0, 1);
      drv(10, 1, 1, 1);
      // backpressure: buffer fills, then drains in order
      base = 32'h100;
      drv(2, 0, 1, 0);
      drv(10, 1, 0, 0);
      drv(10, 1, 1, 1);
      // reset one cycle after a read; the returning word must be dropped
      base = 32'h200;
      drv(2, 0, 1, 0);
      drv(1, 1, 0, 1);
      chk_drain = 0;
      drv(1, 0, 1, 1);
      chk_drain = 1;
      drv(8, 1, 1, 1);
      // beat counter wrap from 0xFFFFFFFE
      base = 32'h300;
      drv(2, 0, 1, 0);
      drv(2, 1, 1, 0);
      wrap_go = 1;
      drv(3, 1, 1, 0);
      drv(3, 1, 0, 1);
      drv(8, 1, 1, 1);
      // random empty/ready traffic
      base = 32'h1000;
      drv(2, 0, 1, 0);
      rst_n = 1;
      rnd(10000);
      drv(20, 1, 1, 1);
      drv(2, 0, 1, 0);
      done = 1;
   end
endmodule
